// File: rtl/register_kris.sv
// register_kris: clock-enabled storage register with synchronous active-high reset.
//   Holds one field of per-frame sprite state: x position, y position, or glyph/movement index.
//   The glyph address generator pulses en for one cycle when RAM read data is valid.
//   Ports:
//     clk   - system clock; all state changes happen on its rising edge
//     reset - synchronous, active-high; loads RESET_VALUE and takes priority over en
//     en    - load enable; when high, d is captured on the next rising edge
//     d     - WIDTH-bit data to capture
//     q     - WIDTH-bit stored value, driven directly by the flops
module register_kris #(
    parameter int unsigned            WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk)
        if (reset) q <= RESET_VALUE;
        else if (en) q <= d;
endmodule

// File: tb/tb_register_kris.sv
// tb_register_kris: scoreboard bench for register_kris at WIDTH 18, 1 and 24.
//   The driver pushes the expected q of each instance for every edge it drives.
//   The monitor pops one entry 1 time unit after each rising edge and compares it.
module tb_register_kris;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic        reset = 1'b0, en = 1'b0;
    logic [17:0] d18 = '0, q18;
    logic        d1 = 1'b0, q1;
    logic [23:0] d24 = '0, q24;
    register_kris #(.WIDTH(18)) dut18 (.clk(clk), .reset(reset), .en(en), .d(d18), .q(q18));
    register_kris #(.WIDTH(1), .RESET_VALUE(1'b1)) dut1 (.clk(clk), .reset(reset), .en(en), .d(d1), .q(q1));
    register_kris #(.WIDTH(24), .RESET_VALUE(24'h98FB98)) dut24 (.clk(clk), .reset(reset), .en(en), .d(d24), .q(q24));
    typedef struct {
        logic [17:0] q18;
        logic        q1;
        logic [23:0] q24;
        string       tag;
    } exp_t;
    exp_t        sb[$];
    exp_t        cur;
    logic [17:0] m18;
    logic        m1;
    logic [23:0] m24;
    int          checks = 0, fails = 0;
    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            chk({cur.tag, "/w18"}, {6'd0, q18}, {6'd0, cur.q18});
            chk({cur.tag, "/w1"}, {23'd0, q1}, {23'd0, cur.q1});
            chk({cur.tag, "/w24"}, q24, cur.q24);
        end
    end
    task automatic step(input logic r, input logic e, input logic [17:0] a, input logic [23:0] b, input string tag);
        exp_t x;
        @(negedge clk);
        reset = r;
        en = e;
        d18 = a;
        d1 = a[0];
        d24 = b;
        if (r) begin
            m18 = 18'h00000;
            m1 = 1'b1;
            m24 = 24'h98FB98;
        end else if (e) begin
            m18 = a;
            m1 = a[0];
            m24 = b;
        end
        x.q18 = m18;
        x.q1 = m1;
        x.q24 = m24;
        x.tag = tag;
        sb.push_back(x);
    endtask
    initial begin
        logic [17:0] hv;
        step(1, 1, 18'h3FFFF, 24'hFFFFFF, "reset1");
        step(1, 1, 18'h3FFFF, 24'hFFFFFF, "reset2");
        step(0, 0, 18'h3FFFF, 24'hFFFFFF, "post_reset_idle");
        step(0, 1, 18'h000C8, 24'h0000C8, "load");
        for (int i = 0; i < 10; i++) begin
            hv = (i % 3 == 0) ? 18'h12345 : (i % 3 == 1) ? 18'h2ABCD : 18'hxxxxx;
            step(0, 0, hv, {6'h3F, hv}, "hold");
        end
        step(1, 1, 18'h1FFFF, 24'hABCDEF, "priority");
        step(0, 1, 18'h00010, 24'h000010, "pulse10");
        step(0, 1, 18'h00020, 24'h000020, "pulse20");
        step(0, 1, 18'h00003, 24'h000003, "pulse3");
        for (int i = 0; i < 3; i++) step(0, 0, 18'h3FFFF, 24'hFFFFFF, "after_pulse");
        step(0, 1, 18'h3FFFF, 24'hFFFFFF, "all_ones");
        step(0, 0, 18'h00000, 24'h000000, "hold_ones");
        step(1, 0, 18'h15555, 24'h555555, "reset_no_en");
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end
endmodule
